// File: rtl/dr_inject_arb.sv
// Round-robin arbiter for one dual-rail (NCL) ring injection point.
// Each grant sends one DATA token and then one NULL token, paced by the ring's ko line.
module dr_inject_arb #(
    parameter int N_REQ = 4,
    parameter int TO_W  = 8
) (
    input  logic             clk50,
    input  logic             key0,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] ack,
    output logic [2:0]       grant_id,
    output logic             dr0,
    output logic             dr1,
    input  logic             ko_in,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, ARB, WAIT_RFD, WAIT_RFN, WAIT_RFD2, ERR} state_t;

    localparam logic [3:0]       NR      = 4'(N_REQ);
    localparam logic [2:0]       LAST    = 3'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);
    // The counter would become all-ones on the next edge, so the wait has
    // lasted 2^TO_W-1 cycles.
    localparam logic [TO_W-1:0]  TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t           state, state_n;
    logic             ko_m, ko_s;
    logic [2:0]       ptr;
    logic             bit_q;
    logic [TO_W-1:0]  cnt;
    logic             timeout, in_wait;
    logic             dr0_d, dr1_d;
    logic             win_found, win_bit;
    logic [2:0]       win_idx;
    logic [3:0]       s;
    logic [N_REQ-1:0] sh_req, sh_din;

    // ptr holds the first index to search, which is one past the last granted index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_bit   = 1'b0;
        s         = '0;
        sh_req    = '0;
        sh_din    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            s = {1'b0, ptr} + 4'(i);
            if (s >= NR) s = s - NR;
            sh_req = req >> s[2:0];
            sh_din = din >> s[2:0];
            if (!win_found && sh_req[0]) begin
                win_found = 1'b1;
                win_idx   = s[2:0];
                win_bit   = sh_din[0];
            end
        end
    end

    assign in_wait = (state == WAIT_RFD) || (state == WAIT_RFN) || (state == WAIT_RFD2);
    assign timeout = in_wait && (cnt == TO_LAST);

    always_ff @(posedge clk50 or negedge key0) begin
        if (!key0) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (win_found) state_n = ARB;
            ARB:       state_n = WAIT_RFD;
            WAIT_RFD:  if (ko_s)      state_n = WAIT_RFN;
                       else if (timeout) state_n = ERR;
            WAIT_RFN:  if (!ko_s)     state_n = WAIT_RFD2;
                       else if (timeout) state_n = ERR;
            WAIT_RFD2: if (ko_s)      state_n = IDLE;
                       else if (timeout) state_n = ERR;
            ERR:       state_n = ERR;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        ack   = (state == WAIT_RFD2 && ko_s) ? (ONE << grant_id) : '0;
        dr1_d = (state_n == WAIT_RFN) &&  bit_q;
        dr0_d = (state_n == WAIT_RFN) && !bit_q;
    end

    always_ff @(posedge clk50 or negedge key0) begin
        if (!key0) begin
            ko_m     <= 1'b0;
            ko_s     <= 1'b0;
            ptr      <= '0;
            grant_id <= '0;
            bit_q    <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
            dr0      <= 1'b0;
            dr1      <= 1'b0;
        end else begin
            ko_m <= ko_in;
            ko_s <= ko_m;
            dr0  <= dr0_d;
            dr1  <= dr1_d;
            if (state_n != state) cnt <= '0;
            else if (in_wait)     cnt <= cnt + TO_W'(1);
            if (state == IDLE && win_found) begin
                grant_id <= win_idx;
                bit_q    <= win_bit;
            end
            if (state == WAIT_RFD2 && ko_s)
                ptr <= (grant_id == LAST) ? 3'd0 : grant_id + 3'd1;
            if (state_n == ERR) err <= 1'b1;
        end
    end

endmodule
